trapez_peak_sampler: RTL and testbench
======================================

// Module: trapez_peak_sampler
// PURPOSE
//  Downstream stage of the trapezoidal shaper; one instance per channel (CHANNEL_SIZE).
//  Consumes the shaped sample stream and detects threshold crossings.
//  Samples the pulse height at the midpoint of the trapezoid flat top and reports it.
//  Each report carries a crossing timestamp and a pile-up flag.
// PARAMETERS
//  DATA_WIDTH  26  shaped sample width, signed (SIZE_SHAPER_DATA_ADD_CAPACITY)
//  RISE_TIME   25  trapezoid rise length in valid samples (k); must be >= 1
//  FLAT_TIME   20  flat-top length in valid samples (l); must be >= 1
//  TAIL_MAX    45  max tail samples above threshold before pile-up (k+l); must be >= 1
//  TIME_WIDTH  16  timestamp counter width (SIZE_INTEGRAL_TIME_COUNTER)
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  reset_n      in   1           asynchronous reset, active low
//  enable       in   1           0 = detector held in IDLE, no reports
//  shaper_valid in   1           shaper_data valid this cycle
//  shaper_data  in   DATA_WIDTH  shaped sample, signed two's complement
//  threshold    in   DATA_WIDTH  trigger level, signed; sampled every valid cycle
//  peak_valid   out  1           one-cycle report strobe
//  peak_height  out  DATA_WIDTH  signed height captured mid flat-top
//  peak_time    out  TIME_WIDTH  timestamp of the crossing sample
//  peak_pileup  out  1           1 = tail timeout (pile-up), height suspect
//  busy         out  1           state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all counters=0; peak_valid=0, peak_height=0, peak_time=0, peak_pileup=0, busy=0.
//  Only cycles with shaper_valid=1 advance anything. Invalid cycles hold all state; peak_valid=0.
//  Timestamp counter:
//   - Each valid sample is tagged with the current count; the count then increments by 1.
//   - Wraps 2^TIME_WIDTH-1 -> 0. Counts regardless of enable.
//  Comparisons are signed: "above" = shaper_data > threshold (strict).
//  Sample index: crossing sample = 0.
//  States:
//   IDLE: valid & enable & above -> RISE; latch timestamp of this sample.
//   RISE: indices 1..RISE_TIME-1.
//     - Any sample not above -> IDLE, no report (noise reject).
//     - The sample at index RISE_TIME-1 -> FLAT.
//   FLAT: indices RISE_TIME..RISE_TIME+FLAT_TIME-1.
//     - Sample not above -> IDLE, no report.
//     - At index RISE_TIME+FLAT_TIME/2 (integer floor) latch shaper_data into the height register.
//     - The last FLAT sample -> TAIL, tail count=0.
//   TAIL: first sample not above -> report with pileup=0, then IDLE.
//     - That sample cannot retrigger; the next above sample can.
//     - TAIL_MAX consecutive above samples -> report with pileup=1, then WAIT_LOW.
//   WAIT_LOW: first sample not above -> IDLE. No report from this state.
//  Report timing:
//   - Registered; peak_valid=1 in the cycle after the deciding sample, for exactly 1 cycle.
//   - peak_height/peak_time/peak_pileup update in the same cycle and hold until the next report.
//  enable=0 in any cycle: state -> IDLE next cycle, pending event discarded.
//   - enable=0 wins over a simultaneous report condition: no strobe.
//  reset_n low mid-event: immediate clear; no report is produced.
//  Threshold changes mid-event take effect on the next valid sample.
//  Defaults: capture at index 35; last FLAT index 44; earliest clean report decided at index 45.
// TESTING
//  1. Trapezoid, rise 0->1000 over 25, flat 1000 x20, fall over 25; threshold=100
//     -> single strobe after first tail sample <=100; height=1000, pileup=0, time=crossing tag.
//  2. Pulse above 100 for only 10 samples -> no strobe; busy drops 1 cycle after the drop.
//  3. Pile-up: second pulse keeps data >100 for >45 tail samples
//     -> one strobe, pileup=1, after tail sample 45; no further strobe until data <=100.
//  4. Gapped valid (1 of 3 cycles) with case-1 data -> identical height/time; strobe cycle shifted.
//  5. reset_n pulsed low during FLAT -> all outputs 0, no strobe.
//     Following clean pulse is reported with timestamp counted from 0.
//  6. Timestamp wrap: preload via 65530 valid samples, crossing at tag 65535
//     -> peak_time=65535; next event tags continue from 0.

Source files
------------

// File: rtl/trapez_peak_sampler.sv
// Per-channel peak sampler behind the trapezoidal shaper: detects a threshold crossing,
// samples the pulse height mid flat-top and reports it with the crossing timestamp and a pile-up flag.
module trapez_peak_sampler #(
  parameter int DATA_WIDTH = 26,
  parameter int RISE_TIME  = 25,
  parameter int FLAT_TIME  = 20,
  parameter int TAIL_MAX   = 45,
  parameter int TIME_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  shaper_valid,
  input  logic [DATA_WIDTH-1:0] shaper_data,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  peak_valid,
  output logic [DATA_WIDTH-1:0] peak_height,
  output logic [TIME_WIDTH-1:0] peak_time,
  output logic                  peak_pileup,
  output logic                  busy
);

  localparam int IW = $clog2(RISE_TIME + FLAT_TIME + 1);
  localparam int TW = $clog2(TAIL_MAX + 1);

  // Sample indices are counted from the crossing sample (index 0).
  localparam logic [IW-1:0] RISE_LAST = IW'(RISE_TIME - 1);
  localparam logic [IW-1:0] CAP_IDX   = IW'(RISE_TIME + FLAT_TIME / 2);
  localparam logic [IW-1:0] FLAT_LAST = IW'(RISE_TIME + FLAT_TIME - 1);
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_MAX - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RISE     = 3'd1,
    ST_FLAT     = 3'd2,
    ST_TAIL     = 3'd3,
    ST_WAIT_LOW = 3'd4
  } state_t;

  function automatic logic is_above(input logic signed [DATA_WIDTH-1:0] d,
                                    input logic signed [DATA_WIDTH-1:0] t);
    return d > t;
  endfunction

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         tail_q, tail_d;
  logic [TIME_WIDTH-1:0] ts_q, ts_d;
  logic [TIME_WIDTH-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0] hgt_q, hgt_d;
  logic                  peak_valid_q, peak_valid_d;
  logic [DATA_WIDTH-1:0] peak_height_q, peak_height_d;
  logic [TIME_WIDTH-1:0] peak_time_q, peak_time_d;
  logic                  peak_pileup_q, peak_pileup_d;
  logic                  busy_q, busy_d;

  logic above_s;
  logic start_s;
  logic capture_s;
  logic report_s;
  logic pileup_s;

  assign above_s = is_above(shaper_data, threshold);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= {IW{1'b0}};
      tail_q        <= {TW{1'b0}};
      ts_q          <= {TIME_WIDTH{1'b0}};
      tag_q         <= {TIME_WIDTH{1'b0}};
      hgt_q         <= {DATA_WIDTH{1'b0}};
      peak_valid_q  <= 1'b0;
      peak_height_q <= {DATA_WIDTH{1'b0}};
      peak_time_q   <= {TIME_WIDTH{1'b0}};
      peak_pileup_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tail_q        <= tail_d;
      ts_q          <= ts_d;
      tag_q         <= tag_d;
      hgt_q         <= hgt_d;
      peak_valid_q  <= peak_valid_d;
      peak_height_q <= peak_height_d;
      peak_time_q   <= peak_time_d;
      peak_pileup_q <= peak_pileup_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic; disable overrides everything, including a pending report.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tail_d    = tail_q;
    start_s   = 1'b0;
    capture_s = 1'b0;
    report_s  = 1'b0;
    pileup_s  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = {IW{1'b0}};
      tail_d  = {TW{1'b0}};
    end else if (shaper_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (above_s) begin
            start_s = 1'b1;
            idx_d   = IW'(1);
            state_d = (RISE_TIME == 1) ? ST_FLAT : ST_RISE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RISE: begin
          if (!above_s) begin
            state_d = ST_IDLE;
            idx_d   = {IW{1'b0}};
          end else if (idx_q == RISE_LAST) begin
            state_d = ST_FLAT;
            idx_d   = idx_q + IW'(1);
          end else begin
            state_d = ST_RISE;
            idx_d   = idx_q + IW'(1);
          end
        end
        ST_FLAT: begin
          if (!above_s) begin
            state_d = ST_IDLE;
            idx_d   = {IW{1'b0}};
          end else begin
            capture_s = (idx_q == CAP_IDX);
            if (idx_q == FLAT_LAST) begin
              state_d = ST_TAIL;
              idx_d   = {IW{1'b0}};
              tail_d  = {TW{1'b0}};
            end else begin
              state_d = ST_FLAT;
              idx_d   = idx_q + IW'(1);
            end
          end
        end
        ST_TAIL: begin
          if (!above_s) begin
            report_s = 1'b1;
            state_d  = ST_IDLE;
            tail_d   = {TW{1'b0}};
          end else if (tail_q == TAIL_LAST) begin
            report_s = 1'b1;
            pileup_s = 1'b1;
            state_d  = ST_WAIT_LOW;
            tail_d   = {TW{1'b0}};
          end else begin
            state_d = ST_TAIL;
            tail_d  = tail_q + TW'(1);
          end
        end
        ST_WAIT_LOW: begin
          if (!above_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_LOW;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = {IW{1'b0}};
          tail_d  = {TW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Timestamp, capture registers and the registered report.
  always_comb begin
    ts_d          = ts_q;
    tag_d         = tag_q;
    hgt_d         = hgt_q;
    peak_valid_d  = 1'b0;
    peak_height_d = peak_height_q;
    peak_time_d   = peak_time_q;
    peak_pileup_d = peak_pileup_q;
    if (shaper_valid) begin
      ts_d = ts_q + TIME_WIDTH'(1);
    end else begin
      ts_d = ts_q;
    end
    if (start_s) begin
      tag_d = ts_q;
    end else begin
      tag_d = tag_q;
    end
    if (capture_s) begin
      hgt_d = shaper_data;
    end else begin
      hgt_d = hgt_q;
    end
    if (report_s) begin
      peak_valid_d  = 1'b1;
      peak_height_d = hgt_q;
      peak_time_d   = tag_q;
      peak_pileup_d = pileup_s;
    end else begin
      peak_valid_d  = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign peak_valid  = peak_valid_q;
  assign peak_height = peak_height_q;
  assign peak_time   = peak_time_q;
  assign peak_pileup = peak_pileup_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_trapez_peak_sampler.sv
// Directed bench for trapez_peak_sampler: table of trapezoid pulses plus hand sequences
// for noise reject, reset mid-event and timestamp wrap.
module tb_trapez_peak_sampler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b1;
  logic        shaper_valid = 1'b0;
  logic [25:0] shaper_data = 26'd0;
  logic [25:0] threshold = 26'd100;
  logic        peak_valid;
  logic [25:0] peak_height;
  logic [15:0] peak_time;
  logic        peak_pileup;
  logic        busy;

  trapez_peak_sampler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .shaper_valid (shaper_valid),
    .shaper_data  (shaper_data),
    .threshold    (threshold),
    .peak_valid   (peak_valid),
    .peak_height  (peak_height),
    .peak_time    (peak_time),
    .peak_pileup  (peak_pileup),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gap;         // invalid cycles after each valid sample
    int base;        // baseline level
    int amp;         // pulse amplitude above baseline
    int slope;       // per-sample increment along the flat top
    int hold;        // extra samples at flat level before the fall
    int thr;         // threshold
    int en_off;      // pulse position from which enable is low (-1 = never)
    int cross_off;   // pulse position of the crossing sample
    int exp_strobes;
    int exp_height;
    int exp_pileup;
  } vec_t;

  vec_t vecs[8];
  vec_t wrap_v;

  int total = 0;
  int bad = 0;
  int ts_sent = 0;
  int strobes = 0;
  logic [25:0] last_h = 26'd0;
  logic [15:0] last_t = 16'd0;
  logic        last_p = 1'b0;

  // Report monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (peak_valid === 1'b1) begin
      strobes <= strobes + 1;
      last_h  <= peak_height;
      last_t  <= peak_time;
      last_p  <= peak_pileup;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send(input int d, input bit en, input int gap);
    shaper_data  = 26'(d);
    enable       = en;
    shaper_valid = 1'b1;
    @(negedge clk);
    shaper_valid = 1'b0;
    ts_sent++;
    repeat (gap) @(negedge clk);
  endtask

  function automatic int value_at(input vec_t v, input int pos);
    if (pos < 25) return v.base + v.amp * (pos + 1) / 25;
    else if (pos < 45) return v.base + v.amp + v.slope * (pos - 25);
    else if (pos < 45 + v.hold) return v.base + v.amp;
    else return v.base + v.amp - v.amp * (pos - 45 - v.hold + 1) / 25;
  endfunction

  task automatic run_pulse(input string name, input vec_t v);
    int ts_start;
    int s0;
    bit en;
    threshold = 26'(v.thr);
    ts_start = ts_sent;
    for (int i = 0; i < 5; i++) send(v.base, 1'b1, v.gap);
    s0 = strobes;
    for (int p = 0; p < 70 + v.hold; p++) begin
      en = !(v.en_off >= 0 && p >= v.en_off);
      send(value_at(v, p), en, v.gap);
    end
    for (int i = 0; i < 5; i++) send(v.base, 1'b1, v.gap);
    chk({name, "_strobes"}, strobes - s0, v.exp_strobes);
    chk({name, "_busy_end"}, busy, 0);
    if (v.exp_strobes > 0) begin
      chk({name, "_height"}, longint'($signed(last_h)), v.exp_height);
      chk({name, "_time"}, last_t, (ts_start + 5 + v.cross_off) & 16'hFFFF);
      chk({name, "_pileup"}, last_p, v.exp_pileup);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ts_sent = 0;
  endtask

  initial begin
    //           gap base  amp  slp hold thr   en_off cross strobes height pileup
    vecs[0] = '{0,   0,    1000, 0, 0,   100,  -1,    2,    1,      1000,  0};
    vecs[1] = '{2,   0,    1000, 0, 0,   100,  -1,    2,    1,      1000,  0};
    vecs[2] = '{0,   0,    1000, 1, 0,   100,  -1,    2,    1,      1012,  0};
    vecs[3] = '{0,   0,    1000, 1, 0,   0,    -1,    0,    1,      1010,  0};
    vecs[4] = '{0,   -500, 1000, 0, 0,   -400, -1,    2,    1,      500,   0};
    vecs[5] = '{0,   0,    1000, 0, 60,  100,  -1,    2,    1,      1000,  1};
    vecs[6] = '{0,   0,    1000, 0, 0,   100,  67,    2,    0,      0,     0};
    vecs[7] = '{0,   0,    1000, 0, 0,   100,  30,    2,    0,      0,     0};
    wrap_v  = '{0,   0,    1000, 0, 0,   0,    -1,    0,    1,      1000,  0};

    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", peak_valid, 0);
    chk("rst_height", peak_height, 0);
    chk("rst_time", peak_time, 0);
    chk("rst_pileup", peak_pileup, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;

    // Short pulse: rejected during rise, busy drops right after the low sample.
    threshold = 26'd100;
    begin
      int s0;
      for (int i = 0; i < 5; i++) send(0, 1'b1, 0);
      s0 = strobes;
      for (int i = 0; i < 10; i++) send(200, 1'b1, 0);
      chk("short_busy_high", busy, 1);
      send(0, 1'b1, 0);
      chk("short_busy_drop", busy, 0);
      for (int i = 0; i < 5; i++) send(0, 1'b1, 0);
      chk("short_strobes", strobes - s0, 0);
    end

    for (int r = 0; r < 8; r++) run_pulse($sformatf("vec%0d", r), vecs[r]);

    // Reset in the middle of the flat top.
    begin
      int s0;
      threshold = 26'd100;
      for (int i = 0; i < 5; i++) send(0, 1'b1, 0);
      s0 = strobes;
      for (int p = 0; p < 36; p++) send(value_at(vecs[0], p), 1'b1, 0);
      chk("mid_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("midrst_height", peak_height, 0);
      chk("midrst_time", peak_time, 0);
      chk("midrst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      ts_sent = 0;
      for (int i = 0; i < 10; i++) send(0, 1'b1, 0);
      chk("midrst_strobes", strobes - s0, 0);
      run_pulse("after_rst", vecs[0]);
    end

    // Timestamp wrap: crossing tagged 65535, next event continues from 0.
    do_reset();
    threshold = 26'd0;
    for (int i = 0; i < 65530; i++) send(0, 1'b1, 0);
    run_pulse("wrap", wrap_v);
    run_pulse("post_wrap", wrap_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
